run_step_ctrl: RTL and testbench



---
 rtl/run_step_ctrl.sv | 98 +++++++++
 tb/tb_run_step_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/run_step_ctrl.sv
// Tick scheduler: HOLD/RUN/STEP modes driving a single-cycle count enable and activity counter.
// Optional macro RATE_CYCLE_EN lets STEP_PRESS in RUN cycle the run-rate select.
module run_step_ctrl #(
  parameter int unsigned DIV_W        = 24,
  parameter int unsigned RATE_DEFAULT = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN_PRESS,
  input  logic       STEP_PRESS,
  output logic       TICK,
  output logic       RUNNING,
  output logic [1:0] RATE,
  output logic [2:0] ACT
);

  typedef enum logic [1:0] {StHold, StRun, StStep} state_e;

  localparam logic [DIV_W:0]   OneExt = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DivOne = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_q;
  logic             running_q;
  logic [2:0]       act_q;
  logic [1:0]       rate;

  logic [5:0]       tap_p1;
  logic [DIV_W:0]   mask_ext;
  logic             run_tick;

  // div[tap:0] all ones, with tap+1 = DIV_W - 2*RATE; extra mask bit absorbs the full-width case
  always_comb begin
    tap_p1   = 6'(DIV_W) - {3'b000, rate, 1'b0};
    mask_ext = (OneExt << tap_p1) - OneExt;
    run_tick = (state_q == StRun) &&
               ((div_q & mask_ext[DIV_W-1:0]) == mask_ext[DIV_W-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StHold;
      div_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      act_q     <= 3'd0;
    end else begin
      tick_q <= (state_q == StStep) || run_tick;
      if (tick_q) act_q <= act_q + 3'd1;
      if (state_q == StRun) div_q <= div_q + DivOne;
      unique case (state_q)
        StHold: begin
          if (RUN_PRESS) begin
            state_q   <= StRun;
            running_q <= 1'b1;
            div_q     <= '0;
          end else if (STEP_PRESS) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (RUN_PRESS) begin
            state_q   <= StHold;
            running_q <= 1'b0;
          end
        end
        StStep: state_q <= StHold;
        default: begin
          state_q   <= StHold;
          running_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RATE_CYCLE_EN
  logic [1:0] rate_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rate_q <= 2'(RATE_DEFAULT);
    end else if ((state_q == StRun) && !RUN_PRESS && STEP_PRESS) begin
      rate_q <= rate_q + 2'd1;
    end
  end

  assign rate = rate_q;
`else
  assign rate = 2'(RATE_DEFAULT);
`endif

  assign TICK    = tick_q;
  assign RUNNING = running_q;
  assign RATE    = rate;
  assign ACT     = act_q;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Self-checking bench for run_step_ctrl: vector table, timed scenarios, random run vs. model.
module tb_run_step_ctrl;

  localparam int unsigned DivW = 8;
`ifdef RATE_CYCLE_EN
  localparam bit RateEn = 1'b1;
`else
  localparam bit RateEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, run_press, step_press;
  logic       tick, running;
  logic [1:0] rate;
  logic [2:0] act;

  int n_checks = 0;
  int n_errors = 0;

  run_step_ctrl #(.DIV_W(DivW), .RATE_DEFAULT(0)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RUN_PRESS (run_press),
    .STEP_PRESS(step_press),
    .TICK      (tick),
    .RUNNING   (running),
    .RATE      (rate),
    .ACT       (act)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=HOLD, 1=RUN, 2=STEP; run ticks when (cycles in run) hits a period
  int m_mode, m_div, m_rate, m_act;
  bit m_tick, prev_tick;

  task automatic model_update(input bit r, input bit u, input bit s);
    int n_mode, n_div, n_rate, n_act;
    bit n_tick;
    if (r) begin
      m_mode = 0; m_div = 0; m_rate = 0; m_act = 0; m_tick = 1'b0;
      return;
    end
    n_tick = (m_mode == 2) ||
             (m_mode == 1 && ((m_div + 1) % (1 << (DivW - 2 * m_rate))) == 0);
    n_act  = m_tick ? (m_act + 1) % 8 : m_act;
    n_div  = (m_mode == 1) ? (m_div + 1) % (1 << DivW) : m_div;
    n_mode = m_mode;
    n_rate = m_rate;
    if (m_mode == 0) begin
      if (u) begin n_mode = 1; n_div = 0; end
      else if (s) n_mode = 2;
    end else if (m_mode == 1) begin
      if (u) n_mode = 0;
      else if (s && RateEn) n_rate = (m_rate + 1) % 4;
    end else begin
      n_mode = 0;
    end
    m_mode = n_mode; m_div = n_div; m_rate = n_rate; m_act = n_act; m_tick = n_tick;
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got tick/run/rate/act=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive on negedge, sample 1 ns after posedge against the model
  task automatic cycle(input bit r, input bit u, input bit s);
    @(negedge clk);
    rst = r; run_press = u; step_press = s;
    @(posedge clk);
    model_update(r, u, s);
    #1;
    chk("model", {tick, running, rate, act},
        {m_tick, m_mode == 1, 2'(m_rate), 3'(m_act)});
    n_checks++;
    if (prev_tick && tick) begin
      n_errors++;
      $display("FAIL back_to_back_tick: got tick=1 twice required no repeat at %0t", $time);
    end
    prev_tick = tick;
  endtask

  task automatic wait_tick(input int limit, output int k);
    k = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0);
      k++;
    end while (!tick && k < limit);
    if (!tick) begin
      n_errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles required a tick", limit);
    end
  endtask

  typedef struct {
    bit r, u, s;
    bit t, run;
    logic [1:0] rt;
    logic [2:0] a;
  } vec_t;

  vec_t vecs[9];
  int   k, per;

  initial begin
    rst = 1'b1; run_press = 1'b0; step_press = 1'b0; prev_tick = 1'b0;
    // Step, coincident presses, reset right after a step press
    vecs[0] = '{1, 0, 0, 0, 0, 2'd0, 3'd0};
    vecs[1] = '{0, 0, 1, 0, 0, 2'd0, 3'd0};
    vecs[2] = '{0, 0, 0, 1, 0, 2'd0, 3'd0};
    vecs[3] = '{0, 0, 0, 0, 0, 2'd0, 3'd1};
    vecs[4] = '{0, 1, 1, 0, 1, 2'd0, 3'd1};
    vecs[5] = '{0, 1, 0, 0, 0, 2'd0, 3'd1};
    vecs[6] = '{0, 0, 1, 0, 0, 2'd0, 3'd1};
    vecs[7] = '{1, 0, 0, 0, 0, 2'd0, 3'd0};
    vecs[8] = '{0, 0, 0, 0, 0, 2'd0, 3'd0};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].u, vecs[i].s);
      chk($sformatf("vec%0d", i), {tick, running, rate, act},
          {vecs[i].t, vecs[i].run, vecs[i].rt, vecs[i].a});
    end

    // Idle in HOLD: never a tick
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("idle", {tick, running, rate, act}, 7'd0);

    // Free run at rate 0: ticks exactly every 256 cycles from the RUN_PRESS edge
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_tick(600, k);
      chk($sformatf("run_period%0d", i), 7'(k), 7'(0) | 7'((k == 256) ? k : 0));
      n_checks++;
      if (k != 256) begin
        n_errors++;
        $display("FAIL run_first_ticks: got gap %0d required 256", k);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
    chk("act_after_3", {4'd0, act}, 7'd3);

    // Rate cycling in RUN: three presses then period 4 (or 256 when rate is fixed)
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
    end
    chk("rate3", {5'd0, rate}, RateEn ? 7'd3 : 7'd0);
    wait_tick(600, k);
    wait_tick(600, per);
    n_checks++;
    if (per != (RateEn ? 4 : 256)) begin
      n_errors++;
      $display("FAIL rate3_period: got %0d required %0d", per, RateEn ? 4 : 256);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("rate_wrap", {5'd0, rate}, 7'd0);
    wait_tick(600, k);
    wait_tick(600, per);
    n_checks++;
    if (per != 256) begin
      n_errors++;
      $display("FAIL rate0_period: got %0d required 256", per);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      cycle($urandom_range(0, 999) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
